// File: rtl/sync_fifo_flags_pkg.sv
// Shared helpers for the flagged synchronous FIFO: pointer sizing for
// arbitrary (non-power-of-two) depths.
package sync_fifo_flags_pkg;

    // Pointer width able to index fifo_depth entries; never below one bit.
    function automatic int unsigned ptr_bits(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, occupancy
// count, programmable almost flags and sticky overflow/underflow flags.
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int data_width          = 8,
    parameter int fifo_depth          = 32,
    parameter int addr_width          = ptr_bits(fifo_depth),
    parameter int fwft                = 0,
    parameter int almost_full_thresh  = fifo_depth - 2,
    parameter int almost_empty_thresh = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [data_width-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [data_width-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [addr_width-1:0] last_ptr_c = addr_width'(fifo_depth - 1);
    localparam logic [addr_width:0]   depth_c    = (addr_width + 1)'(fifo_depth);
    localparam logic [addr_width:0]   af_c       = (addr_width + 1)'(almost_full_thresh);
    localparam logic [addr_width:0]   ae_c       = (addr_width + 1)'(almost_empty_thresh);

    logic [data_width-1:0] mem_q [fifo_depth];
    logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Explicit wrap so depths that are not a power of two cycle correctly.
    function automatic logic [addr_width-1:0] ptr_inc(input logic [addr_width-1:0] p);
        return (p == last_ptr_c) ? '0 : p + 1'b1;
    endfunction

    // Flags come only from registered count: no path from wr_en/rd_en.
    assign full         = (count_q == depth_c);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= af_c);
    assign almost_empty = (count_q <= ae_c);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q  | (wr_en && full);
        underflow_d = underflow_q | (rd_en && empty);
        if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset, keeping it mappable to distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

    generate
        if (fwft != 0) begin : g_fwft
            assign dout = mem_q[rd_ptr_q];
        end else begin : g_std
            logic [data_width-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst)         dout_q <= '0;
                else if (rd_acc) dout_q <= mem_q[rd_ptr_q];
            end
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench: four FIFO configurations driven from shared
// stimulus, each checked only while its own scenario runs.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] din;

    int n_checks = 0;
    int n_fail   = 0;

    // a: depth 4 standard; b: depth 5 standard; c: depth 4 FWFT; d: depth 8, af 6, ae 2
    logic a_full, a_af, a_empty, a_ae, a_ovf, a_udf; logic [7:0] a_dout; logic [2:0] a_count;
    logic b_full, b_af, b_empty, b_ae, b_ovf, b_udf; logic [7:0] b_dout; logic [3:0] b_count;
    logic c_full, c_af, c_empty, c_ae, c_ovf, c_udf; logic [7:0] c_dout; logic [2:0] c_count;
    logic d_full, d_af, d_empty, d_ae, d_ovf, d_udf; logic [7:0] d_dout; logic [3:0] d_count;

    always #5 clk = ~clk;

    sync_fifo_flags #(.data_width(8), .fifo_depth(4), .fwft(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(a_full), .almost_full(a_af),
        .rd_en(rd_en), .dout(a_dout), .empty(a_empty), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf));

    sync_fifo_flags #(.data_width(8), .fifo_depth(5), .fwft(0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(b_full), .almost_full(b_af),
        .rd_en(rd_en), .dout(b_dout), .empty(b_empty), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf));

    sync_fifo_flags #(.data_width(8), .fifo_depth(4), .fwft(1)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(c_full), .almost_full(c_af),
        .rd_en(rd_en), .dout(c_dout), .empty(c_empty), .almost_empty(c_ae), .count(c_count),
        .overflow(c_ovf), .underflow(c_udf));

    sync_fifo_flags #(.data_width(8), .fifo_depth(8), .fwft(0),
                      .almost_full_thresh(6), .almost_empty_thresh(2)) u_d (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(d_full), .almost_full(d_af),
        .rd_en(rd_en), .dout(d_dout), .empty(d_empty), .almost_empty(d_ae), .count(d_count),
        .overflow(d_ovf), .underflow(d_udf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; outputs are sampled 1 ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        din   = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         max_cnt;

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        // Reset then idle, depth 4
        do_reset();
        cyc(1'b0, 1'b0, 8'h00);
        check("a_rst_empty", 32'(a_empty), 32'd1);
        check("a_rst_ae",    32'(a_ae),    32'd1);
        check("a_rst_count", 32'(a_count), 32'd0);
        check("a_rst_full",  32'(a_full),  32'd0);
        check("a_rst_af",    32'(a_af),    32'd0);
        check("a_rst_ovf",   32'(a_ovf),   32'd0);
        check("a_rst_udf",   32'(a_udf),   32'd0);
        check("a_rst_dout",  32'(a_dout),  32'd0);

        // Depth 5, standard mode: fill, overflow, drain in order
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 8'h11 + 8'(i));
            check("b_fill_count", 32'(b_count), 32'(i + 1));
            check("b_fill_full",  32'(b_full),  (i == 4) ? 32'd1 : 32'd0);
        end
        check("b_full_empty", 32'(b_empty), 32'd0);
        check("b_pre_ovf",    32'(b_ovf),   32'd0);
        cyc(1'b1, 1'b0, 8'h99);
        check("b_ovf",       32'(b_ovf),   32'd1);
        check("b_ovf_count", 32'(b_count), 32'd5);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("b_rd_dout",  32'(b_dout),  32'h11 + 32'(i));
            check("b_rd_count", 32'(b_count), 32'(4 - i));
            if (i == 0) check("b_full_drop", 32'(b_full), 32'd0);
        end
        check("b_drain_empty", 32'(b_empty), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        check("b_udf",       32'(b_udf),  32'd1);
        check("b_udf_dout",  32'(b_dout), 32'h15);
        check("b_ovf_stick", 32'(b_ovf),  32'd1);

        // Wrap, depth 4: 10 rounds of write-2/read-2
        do_reset();
        wdata   = 8'h30;
        rdata   = 8'h30;
        max_cnt = 0;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 2; k++) begin
                cyc(1'b1, 1'b0, wdata);
                wdata++;
                if (int'(a_count) > max_cnt) max_cnt = int'(a_count);
            end
            for (int k = 0; k < 2; k++) begin
                cyc(1'b0, 1'b1, 8'h00);
                check("a_wrap_dout", 32'(a_dout), 32'(rdata));
                rdata++;
            end
        end
        check("a_wrap_maxcnt", 32'(max_cnt), 32'd2);
        check("a_wrap_empty",  32'(a_empty), 32'd1);
        check("a_wrap_ovf",    32'(a_ovf),   32'd0);

        // Simultaneous read+write while full
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h40 + 8'(i));
        check("a_sim_full", 32'(a_full), 32'd1);
        cyc(1'b1, 1'b1, 8'hEE);
        check("a_simf_count", 32'(a_count), 32'd3);
        check("a_simf_ovf",   32'(a_ovf),   32'd1);
        check("a_simf_dout",  32'(a_dout),  32'h40);
        check("a_simf_full",  32'(a_full),  32'd0);
        for (int i = 1; i < 4; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("a_simf_rest", 32'(a_dout), 32'h40 + 32'(i));
        end

        // Simultaneous read+write while empty
        do_reset();
        cyc(1'b1, 1'b1, 8'h77);
        check("a_sime_count", 32'(a_count), 32'd1);
        check("a_sime_udf",   32'(a_udf),   32'd1);
        check("a_sime_dout",  32'(a_dout),  32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        check("a_sime_read",  32'(a_dout),  32'h77);

        // FWFT
        do_reset();
        cyc(1'b1, 1'b0, 8'hA5);
        check("c_fwft_empty", 32'(c_empty), 32'd0);
        check("c_fwft_dout",  32'(c_dout),  32'hA5);
        cyc(1'b1, 1'b0, 8'h5C);
        check("c_fwft_hold",  32'(c_dout),  32'hA5);
        cyc(1'b0, 1'b1, 8'h00);
        check("c_fwft_next",  32'(c_dout),  32'h5C);
        check("c_fwft_cnt",   32'(c_count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00);
        check("c_fwft_pop",   32'(c_empty), 32'd1);
        check("c_fwft_udf",   32'(c_udf),   32'd0);

        // Thresholds, depth 8, af 6, ae 2
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            check("d_thr_ae", 32'(d_ae), (i <= 2) ? 32'd1 : 32'd0);
            check("d_thr_af", 32'(d_af), (i >= 6) ? 32'd1 : 32'd0);
        end
        check("d_thr_count", 32'(d_count), 32'd6);
        cyc(1'b0, 1'b1, 8'h00);
        check("d_thr_dout", 32'(d_dout), 32'd1);
        do_reset();
        check("d_rst_count", 32'(d_count), 32'd0);
        check("d_rst_empty", 32'(d_empty), 32'd1);
        check("d_rst_ae",    32'(d_ae),    32'd1);
        check("d_rst_af",    32'(d_af),    32'd0);
        check("d_rst_full",  32'(d_full),  32'd0);
        check("d_rst_dout",  32'(d_dout),  32'd0);
        check("d_rst_ovf",   32'(d_ovf),   32'd0);
        check("d_rst_udf",   32'(d_udf),   32'd0);
        cyc(1'b1, 1'b0, 8'h5A);
        cyc(1'b0, 1'b1, 8'h00);
        check("d_post_rst_dout", 32'(d_dout), 32'h5A);
        check("d_post_rst_empty", 32'(d_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO that generalises the basic `fifo`. It supports arbitrary (non-power-of-two) depth, selectable standard or first-word-fall-through (FWFT) read mode, and an occupancy count. It also provides programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It is used between the UART, memory-mapped I/O and any producer/consumer pair that needs back-pressure warning before hard full.

## Interface
- `data_width`, 8: word width in bits.
- `fifo_depth`, 32: number of entries, any value ≥ 2.
- `addr_width`, `` `log2(fifo_depth) ``: pointer width.
- `fwft`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `almost_full_thresh`, `fifo_depth-2`: `almost_full` asserts when count ≥ this value.
- `almost_empty_thresh`, 2: `almost_empty` asserts when count ≤ this value.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write request.
- `din` in `data_width`: write data.
- `full` out 1: count == `fifo_depth`.
- `almost_full` out 1: count ≥ `almost_full_thresh`.
- `rd_en` in 1: read/pop request.
- `dout` out `data_width`: read data.
- `empty` out 1: count == 0.
- `almost_empty` out 1: count ≤ `almost_empty_thresh`.
- `count` out `addr_width+1`: current occupancy, 0..`fifo_depth`.
- `overflow` out 1: sticky; set by `wr_en` while `full`.
- `underflow` out 1: sticky; set by `rd_en` while `empty`.

## Operation
- Write accepted iff `wr_en && !full`: `data[wr_ptr] <= din`; `wr_ptr` advances.
- Read accepted iff `rd_en && !empty`: `rd_ptr` advances.
- Pointer wrap: `fifo_depth-1` → 0. Do not rely on natural binary overflow; depth need not be a power of two.
- `count` update per edge: +1 on write-only, −1 on read-only, unchanged on both or neither.
- All flags are derived combinationally from registered `count`, so they change in the same cycle as `count`.
- Simultaneous events:
  - Both requests while full: the read is accepted; the write is rejected and `overflow` is set. `full` is the gating signal, not a look-ahead.
  - Both requests while empty: the write is accepted; the read is rejected and `underflow` is set.
  - Both requests otherwise: both are accepted and `count` is unchanged.
- Rejected requests never modify memory, pointers or `count`.
- Standard mode (`fwft=0`): an accepted read loads `dout <= data[rd_ptr]` at that edge. `dout` holds its value otherwise, including across rejected reads.
- FWFT mode (`fwft=1`):
  - `dout = data[rd_ptr]` combinationally.
  - Valid whenever `!empty`, undefined-but-stable when empty.
  - `rd_en` acts as an acknowledge/pop.
- `overflow` and `underflow` are cleared only by `rst`.
- Reset: pointers 0, `count` 0, `empty` 1, `full` 0, `almost_empty` 1, `almost_full` 0 (given thresh ≥ 1), `overflow` 0, `underflow` 0, registered `dout` 0. Memory array is not reset.
- Reset mid-operation discards all contents. The first read after reset sees only post-reset writes.

## Timing
- Write-to-`empty` deassert: 1 cycle. A write at edge N gives `empty`=0 in cycle N+1.
- Standard read latency: `dout` is valid the cycle after the edge that accepted `rd_en`.
- FWFT latency: the first word appears on `dout` in the same cycle `empty` drops, 1 cycle after the write edge.
- `full` deasserts the cycle after an accepted read.
- Throughput: one write and one read per cycle sustained.
- No combinational path from `wr_en`/`rd_en` to `full`/`empty`/`count`.

## Structure
- Use the `` `log2 `` macro from `util.vh` for `addr_width`. No new shared header is needed.
- No sub-module. Pointer increment-with-wrap is a local Verilog function used for both pointers.
- Memory is a plain reg array, suitable for distributed RAM inference.

## Test plan
- Reset then idle, depth 4: `empty`=1, `almost_empty`=1, `count`=0, `full`=0, error flags 0.
- Depth 5 (non-power-of-two), standard mode:
  - Write 0x11..0x15: `full`=1 after 5th edge, `count`=5.
  - 6th write sets `overflow`.
  - Read 5 words: `dout` gives 0x11..0x15 in order, one cycle after each accepted `rd_en`.
- Wrap: depth 4, 10 rounds of write-2/read-2 with incrementing data: all data returned in order, `count` never exceeds 2.
- Simultaneous events, depth 4, standard mode:
  - Full with `wr_en`=`rd_en`=1: `count` 4→3, `overflow`=1, returns the oldest word.
  - Empty with both asserted: `count` 0→1, `underflow`=1.
- FWFT mode: write 0xA5 at edge N: `empty`=0 and `dout`=0xA5 in cycle N+1 without `rd_en`. Pop returns to `empty`=1.
- Thresholds, depth 8, af=6, ae=2: `almost_empty` drops at `count`=3; `almost_full` rises at `count`=6. Mid-fill `rst` returns all outputs to reset values.
